// File: rtl/bias_bank_loader_l9_pkg.sv
// rtl/bias_bank_loader_l9_pkg.sv - shared layer-9 bias loader constants, state encoding and width helper
package bias_bank_loader_l9_pkg;

  localparam int BIAS_W  = 18;
  localparam int N_BANKS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_bank_loader_l9_bank_reg.sv
// rtl/bias_bank_loader_l9_bank_reg.sv - one bias bank register, writes a single word slice per enable
module bias_bank_loader_l9_bank_reg
  import bias_bank_loader_l9_pkg::*;
#(
  parameter int N_WORDS = 16,
  parameter int W       = BIAS_W,
  parameter int IW      = cnt_width(N_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [IW-1:0]        idx_i,
  input  logic [W-1:0]         data_i,
  output logic [N_WORDS*W-1:0] bank_o
);

  logic [N_WORDS*W-1:0] bank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
    end else begin
      for (int i = 0; i < N_WORDS; i++) begin
        if (we_i && (idx_i == IW'(i))) begin
          bank_q[i*W +: W] <= data_i;
        end
      end
    end
  end

  assign bank_o = bank_q;

endmodule

// File: rtl/bias_bank_loader_l9.sv
// rtl/bias_bank_loader_l9.sv - streams 18-bit bias words into eight parallel banks for the layer-9 bias mux
// Optional running checksum of accepted words enabled by BIAS_LOADER_CHECKSUM_EN.
module bias_bank_loader_l9
  import bias_bank_loader_l9_pkg::*;
#(
  parameter int N_adder_tree = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [BIAS_W-1:0]              bias_in,
  input  logic                           bias_valid,
`ifdef BIAS_LOADER_CHECKSUM_EN
  input  logic [BIAS_W-1:0]              chk_in,
  output logic                           chk_err,
`endif
  output logic                           bias_ready,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_1,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_2,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_3,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_4,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_5,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_6,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_7,
  output logic [N_adder_tree*BIAS_W-1:0] BIAS_8,
  output logic [N_BANKS-1:0]             bank_valid,
  output logic                           load_done,
  output logic                           load_busy
);

  localparam int WCW    = cnt_width(N_adder_tree);
  localparam int BCW    = cnt_width(N_BANKS);
  localparam int BANK_W = N_adder_tree * BIAS_W;

  state_e               state_q;
  logic [WCW-1:0]       word_cnt_q;
  logic [BCW-1:0]       bank_cnt_q;
  logic [N_BANKS-1:0]   bank_valid_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 xfer;
  logic                 last_word;
  logic                 last_xfer;
  logic [BANK_W-1:0]    bank_w [N_BANKS];

  // A start in the same cycle as a handshake wins: that word is dropped.
  assign xfer      = bias_valid && ready_q && !start;
  assign last_word = (word_cnt_q == WCW'(N_adder_tree - 1));
  assign last_xfer = xfer && last_word && (bank_cnt_q == BCW'(N_BANKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      bank_cnt_q   <= '0;
      bank_valid_q <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_LOAD: begin
          if (start) begin
            state_q      <= ST_LOAD;
            word_cnt_q   <= '0;
            bank_cnt_q   <= '0;
            bank_valid_q <= '0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end else if (xfer) begin
            if (last_word) begin
              word_cnt_q               <= '0;
              bank_valid_q[bank_cnt_q] <= 1'b1;
              bank_cnt_q               <= bank_cnt_q + BCW'(1);
            end else begin
              word_cnt_q <= word_cnt_q + WCW'(1);
            end
            if (last_xfer) begin
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    bias_bank_loader_l9_bank_reg #(
      .N_WORDS (N_adder_tree),
      .W       (BIAS_W),
      .IW      (WCW)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .we_i   (xfer && (bank_cnt_q == BCW'(b))),
      .idx_i  (word_cnt_q),
      .data_i (bias_in),
      .bank_o (bank_w[b])
    );
  end

  assign BIAS_1     = bank_w[0];
  assign BIAS_2     = bank_w[1];
  assign BIAS_3     = bank_w[2];
  assign BIAS_4     = bank_w[3];
  assign BIAS_5     = bank_w[4];
  assign BIAS_6     = bank_w[5];
  assign BIAS_7     = bank_w[6];
  assign BIAS_8     = bank_w[7];
  assign bank_valid = bank_valid_q;
  assign bias_ready = ready_q;
  assign load_busy  = busy_q;
  assign load_done  = done_q;

`ifdef BIAS_LOADER_CHECKSUM_EN
  logic [BIAS_W-1:0] sum_q;
  logic [BIAS_W-1:0] chk_q;
  logic              chk_err_q;

  // The final word is folded in directly so the verdict is ready on the DONE entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      chk_q     <= '0;
      chk_err_q <= 1'b0;
    end else if (start) begin
      sum_q     <= '0;
      chk_q     <= chk_in;
      chk_err_q <= 1'b0;
    end else if (xfer) begin
      sum_q <= sum_q + bias_in;
      if (last_xfer) begin
        chk_err_q <= ((sum_q + bias_in) != chk_q);
      end
    end
  end

  assign chk_err = chk_err_q;
`endif

endmodule
